ff_fifo_pow2_checked: RTL and testbench

Synchronous flip-flop-based FIFO with power-of-two depth and first-word-fall-through read data. It includes an embedded protocol/data checker with a reference queue model that flags misuse and data corruption. It is used as a general stream buffer between producer and consumer logic in one clock domain.

---
 rtl/ff_fifo_pow2_checked_if.sv | 20 ++
 rtl/ff_fifo_pow2_checked.sv | 74 +++++++
 tb/tb_ff_fifo_pow2_checked.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/ff_fifo_pow2_checked_if.sv
// ff_fifo_pow2_checked_if: FIFO handshake bundle; master drives push/pop/write_data, slave returns read_data/empty/full/err_*
interface ff_fifo_pow2_checked_if #(parameter int width = 8);
  logic push;
  logic pop;
  logic [width-1:0] write_data;
  logic [width-1:0] read_data;
  logic empty;
  logic full;
  logic err_overflow;
  logic err_underflow;
  logic err_data;
  modport master (
    output push, pop, write_data,
    input read_data, empty, full, err_overflow, err_underflow, err_data
  );
  modport slave (
    input push, pop, write_data,
    output read_data, empty, full, err_overflow, err_underflow, err_data
  );
endinterface

// File: rtl/ff_fifo_pow2_checked.sv
// ff_fifo_pow2_checked: power-of-two FWFT flop FIFO with reference-model checker; ports clk, rst (async high), bus (push/pop/write_data in, read_data/empty/full/err_* out)
module ff_fifo_pow2_checked #(
  parameter int width = 8,
  parameter int depth = 8,
  parameter bit allow_push_when_full_with_pop = 1'b1
) (
  input logic clk,
  input logic rst,
  ff_fifo_pow2_checked_if.slave bus
);
  localparam int aw = $clog2(depth);
  localparam logic [aw:0] one_p = 1;
  localparam logic [aw-1:0] one_a = 1;
  localparam logic [aw:0] full_cnt = (aw + 1)'(depth);
  if (depth < 2 || (depth & (depth - 1)) != 0) begin : g_bad_depth
    $error("ff_fifo_pow2_checked: depth must be a power of two >= 2");
  end
  logic [width-1:0] mem [depth];
  logic [aw:0] wr_ptr, rd_ptr;
  logic do_push, do_pop, empty, full;
  logic [width-1:0] shadow [depth];
  logic [aw-1:0] m_head, m_tail;
  logic [aw:0] m_cnt;
  logic m_empty, m_full, m_push, m_pop;
  logic err_overflow, err_underflow, err_data;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[aw-1:0] == rd_ptr[aw-1:0]) && (wr_ptr[aw] != rd_ptr[aw]);
  assign do_pop = bus.pop && !empty;
  assign do_push = bus.push && (!full || (bus.pop && allow_push_when_full_with_pop));
  assign bus.empty = empty;
  assign bus.full = full;
  assign bus.read_data = mem[rd_ptr[aw-1:0]];
  assign bus.err_overflow = err_overflow;
  assign bus.err_underflow = err_underflow;
  assign bus.err_data = err_data;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < depth; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[aw-1:0]] <= bus.write_data;
        wr_ptr <= wr_ptr + one_p;
      end
      if (do_pop) rd_ptr <= rd_ptr + one_p;
    end
  end
  assign m_empty = m_cnt == '0;
  assign m_full = m_cnt == full_cnt;
  assign m_pop = bus.pop && !m_empty;
  assign m_push = bus.push && (!m_full || (bus.pop && allow_push_when_full_with_pop));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt <= '0;
      m_head <= '0;
      m_tail <= '0;
      err_overflow <= 1'b0;
      err_underflow <= 1'b0;
      err_data <= 1'b0;
      for (int i = 0; i < depth; i++) shadow[i] <= '0;
    end else begin
      if (m_push) begin
        shadow[m_tail] <= bus.write_data;
        m_tail <= m_tail + one_a;
      end
      if (m_pop) m_head <= m_head + one_a;
      m_cnt <= m_cnt + (aw + 1)'(m_push) - (aw + 1)'(m_pop);
      err_overflow <= err_overflow | (bus.push && full && !(bus.pop && allow_push_when_full_with_pop));
      err_underflow <= err_underflow | (bus.pop && empty);
      err_data <= err_data | (m_pop && bus.read_data != shadow[m_head]) | (empty != m_empty) | (full != m_full);
    end
  end
endmodule

// File: tb/tb_ff_fifo_pow2_checked.sv
// tb_ff_fifo_pow2_checked: scoreboard bench for ff_fifo_pow2_checked (allow=1 main instance, allow=0 secondary instance)
module tb_ff_fifo_pow2_checked;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] q[$];
  logic exp_ovf = 1'b0;
  logic exp_udf = 1'b0;
  ff_fifo_pow2_checked_if #(.width(8)) a();
  ff_fifo_pow2_checked_if #(.width(8)) b();
  ff_fifo_pow2_checked #(.width(8), .depth(8), .allow_push_when_full_with_pop(1'b1)) dut1 (
    .clk(clk), .rst(rst), .bus(a)
  );
  ff_fifo_pow2_checked #(.width(8), .depth(8), .allow_push_when_full_with_pop(1'b0)) dut0 (
    .clk(clk), .rst(rst), .bus(b)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_state();
    chk("empty", 32'(a.empty), 32'(q.size() == 0));
    chk("full", 32'(a.full), 32'(q.size() == 8));
    if (q.size() != 0) chk("head", 32'(a.read_data), 32'(q[0]));
    chk("err_overflow", 32'(a.err_overflow), 32'(exp_ovf));
    chk("err_underflow", 32'(a.err_underflow), 32'(exp_udf));
    chk("err_data", 32'(a.err_data), 32'h0);
  endtask
  task automatic cycle(input logic p, input logic o, input logic [7:0] d);
    logic ap, ao;
    logic [7:0] e;
    a.push = p;
    a.pop = o;
    a.write_data = d;
    ao = o && q.size() != 0;
    ap = p && (q.size() < 8 || o);
    if (o && q.size() == 0) exp_udf = 1'b1;
    if (p && q.size() == 8 && !o) exp_ovf = 1'b1;
    if (ao) begin
      e = q.pop_front();
      chk("pop_data", 32'(a.read_data), 32'(e));
    end
    if (ap) q.push_back(d);
    @(negedge clk);
    a.push = 1'b0;
    a.pop = 1'b0;
    chk_state();
  endtask
  task automatic drain();
    for (int i = 0; i < 9 && q.size() != 0; i++) cycle(1'b0, 1'b1, 8'h00);
    chk("drained", 32'(a.empty), 32'h1);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    q.delete();
    exp_ovf = 1'b0;
    exp_udf = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_read_data", 32'(a.read_data), 32'h0);
    chk_state();
    rst = 1'b0;
  endtask
  initial begin
    a.push = 1'b0; a.pop = 1'b0; a.write_data = '0;
    b.push = 1'b0; b.pop = 1'b0; b.write_data = '0;
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 8'(i * 8'h11));
    chk("fill_full", 32'(a.full), 32'h1);
    drain();
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'(i * 8'h11));
    for (int k = 0; k < 40; k++) begin
      cycle(1'b1, 1'b1, 8'((k % 8) * 8'h11));
      chk("b2b_occ", 32'(q.size()), 32'd4);
    end
    drain();
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 8'(i * 8'h11));
    cycle(1'b1, 1'b1, 8'hAB);
    chk("full_pop_push_full", 32'(a.full), 32'h1);
    drain();
    cycle(1'b0, 1'b1, 8'h00);
    chk("underflow_flag", 32'(a.err_underflow), 32'h1);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 8'(8'h80 + i));
    cycle(1'b1, 1'b0, 8'hCD);
    chk("overflow_flag", 32'(a.err_overflow), 32'h1);
    drain();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'(8'h30 + i));
    #2 rst = 1'b1;
    #1 chk("async_rst_empty", 32'(a.empty), 32'h1);
    chk("async_rst_data", 32'(a.read_data), 32'h0);
    chk("async_rst_ovf", 32'(a.err_overflow), 32'h0);
    @(negedge clk);
    do_reset();
    for (int k = 0; k < 100; k++) begin
      logic p, o;
      if (q.size() == 8) begin
        p = $urandom_range(99) < 40;
        o = p || ($urandom_range(99) < 50);
      end else begin
        p = $urandom_range(99) < 60;
        o = q.size() != 0 && $urandom_range(99) < 50;
      end
      cycle(p, o, 8'($urandom_range(255)));
    end
    drain();
    for (int i = 0; i < 8; i++) begin
      b.push = 1'b1;
      b.write_data = 8'(i * 8'h11);
      @(negedge clk);
    end
    chk("p0_full", 32'(b.full), 32'h1);
    b.pop = 1'b1;
    b.write_data = 8'hAB;
    chk("p0_pop_data", 32'(b.read_data), 32'h00);
    @(negedge clk);
    b.push = 1'b0;
    b.pop = 1'b0;
    chk("p0_full_after", 32'(b.full), 32'h0);
    chk("p0_overflow", 32'(b.err_overflow), 32'h1);
    for (int i = 1; i < 8; i++) begin
      b.pop = 1'b1;
      chk("p0_drain", 32'(b.read_data), 32'(i * 8'h11));
      @(negedge clk);
    end
    b.pop = 1'b0;
    chk("p0_empty", 32'(b.empty), 32'h1);
    chk("p0_err_data", 32'(b.err_data), 32'h0);
    chk("p0_underflow", 32'(b.err_underflow), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
